uart_tx_framer: RTL and testbench

- Downstream consumer of the ciphertext byte FIFO; replaces the ad-hoc FIFO-to-UART glue on the transmit path.
- Pops bytes from the FIFO and drives the UART transmitter one byte at a time using its strobe/done handshake.
- Wraps each group of PAYLOAD_LEN bytes in a frame: sync byte, length byte, payload, optional XOR checksum. The host can then resynchronise after dropped or garbled bytes.

---
 rtl/uart_tx_framer_if.sv | 20 ++
 rtl/uart_tx_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// FIFO-pop and UART-transmit handshake bundle between the framer (master)
// and the FIFO/transmitter pair (slave).
interface uart_tx_framer_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       xmit;
    logic [7:0] xmit_data;
    logic       xmit_done;

    modport master (
        input  fifo_empty, fifo_dout, xmit_done,
        output fifo_rd_en, xmit, xmit_data
    );

    modport slave (
        output fifo_empty, fifo_dout, xmit_done,
        input  fifo_rd_en, xmit, xmit_data
    );
endinterface

// File: rtl/uart_tx_framer.sv
// Frames ciphertext bytes from the FIFO as SYNC, LEN, payload[, XOR checksum] for the UART.
// Optional checksum byte enabled by defining FRAMER_CHECKSUM_EN.
module uart_tx_framer #(
    parameter int         PAYLOAD_LEN = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_framer_if.master bus,
    output logic             busy,
    output logic             pad_flag,
    output logic [15:0]      frame_cnt
);

    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]  LEN_BYTE = 8'(PAYLOAD_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_CAP  = 3'd4;
    localparam logic [2:0] ST_PAY  = 3'd5;
    localparam logic [2:0] ST_WAIT = 3'd6;
`ifdef FRAMER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd7;
    localparam logic [2:0] LAST_RET = ST_CSUM;
`else
    localparam logic [2:0] LAST_RET = ST_IDLE;
`endif

    logic [2:0]    state_reg, state_next;
    logic [2:0]    ret_reg, ret_next;
    logic [7:0]    data_reg, data_next;
    logic          xmit_reg, xmit_next;
    logic          rd_en_reg, rd_en_next;
    logic          pad_flag_reg, pad_flag_next;
    logic          busy_reg, busy_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;
    logic [7:0]    byte_cnt_reg, byte_cnt_next;
    logic          pad_mode_reg, pad_mode_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          done_prev_reg;
    logic          done_rise;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]    csum_reg, csum_next;
`endif

    // Previous sample resets high so an idle transmitter produces no edge after reset.
    assign done_rise = bus.xmit_done & ~done_prev_reg;

    always_comb begin
        state_next     = state_reg;
        ret_next       = ret_reg;
        data_next      = data_reg;
        xmit_next      = 1'b0;
        rd_en_next     = 1'b0;
        pad_flag_next  = 1'b0;
        busy_next      = busy_reg;
        frame_cnt_next = frame_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        pad_mode_next  = pad_mode_reg;
        tmo_next       = tmo_reg;
`ifdef FRAMER_CHECKSUM_EN
        csum_next      = csum_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    state_next = ST_SYNC;
                    xmit_next  = 1'b1;
                    data_next  = SYNC_BYTE;
                    busy_next  = 1'b1;
                end
            end
            ST_SYNC: begin
                ret_next   = ST_LEN;
                state_next = ST_WAIT;
                busy_next  = 1'b1;
            end
            ST_LEN: begin
                ret_next   = ST_RD;
                state_next = ST_WAIT;
            end
            ST_RD: begin
                // A pop issued on the previous cycle returns data now; capture next.
                if (rd_en_reg) begin
                    state_next = ST_CAP;
                end else if (!bus.fifo_empty) begin
                    rd_en_next = 1'b1;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                    if (tmo_next == TMO_LAST) begin
                        pad_flag_next = 1'b1;
                        pad_mode_next = 1'b1;
                        xmit_next     = 1'b1;
                        data_next     = 8'h00;
                        tmo_next      = '0;
                        state_next    = ST_PAY;
                    end
                end
            end
            ST_CAP: begin
                data_next  = bus.fifo_dout;
                xmit_next  = 1'b1;
                state_next = ST_PAY;
`ifdef FRAMER_CHECKSUM_EN
                csum_next  = csum_reg ^ bus.fifo_dout;
`endif
            end
            ST_PAY: begin
                byte_cnt_next = byte_cnt_reg + 8'd1;
                state_next    = ST_WAIT;
                ret_next      = (byte_cnt_next == LEN_BYTE) ? LAST_RET : ST_RD;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    case (ret_reg)
                        ST_LEN: begin
                            xmit_next  = 1'b1;
                            data_next  = LEN_BYTE;
                            state_next = ST_LEN;
`ifdef FRAMER_CHECKSUM_EN
                            csum_next  = csum_reg ^ LEN_BYTE;
`endif
                        end
                        ST_RD: begin
                            if (pad_mode_reg) begin
                                xmit_next  = 1'b1;
                                data_next  = 8'h00;
                                state_next = ST_PAY;
                            end else begin
                                rd_en_next = ~bus.fifo_empty;
                                if (!bus.fifo_empty) tmo_next = '0;
                                state_next = ST_RD;
                            end
                        end
`ifdef FRAMER_CHECKSUM_EN
                        ST_CSUM: begin
                            xmit_next  = 1'b1;
                            data_next  = csum_reg;
                            state_next = ST_CSUM;
                        end
`endif
                        default: begin
                            // Frame end; a waiting FIFO restarts the next frame immediately.
                            frame_cnt_next = frame_cnt_reg + 16'd1;
                            pad_mode_next  = 1'b0;
                            byte_cnt_next  = 8'd0;
                            tmo_next       = '0;
                            busy_next      = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
                            csum_next      = 8'h00;
`endif
                            if (!bus.fifo_empty) begin
                                state_next = ST_SYNC;
                                xmit_next  = 1'b1;
                                data_next  = SYNC_BYTE;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                ret_next   = ST_IDLE;
                state_next = ST_WAIT;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ret_reg       <= ST_IDLE;
            data_reg      <= 8'h00;
            xmit_reg      <= 1'b0;
            rd_en_reg     <= 1'b0;
            pad_flag_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            frame_cnt_reg <= 16'd0;
            byte_cnt_reg  <= 8'd0;
            pad_mode_reg  <= 1'b0;
            tmo_reg       <= '0;
            done_prev_reg <= 1'b1;
`ifdef FRAMER_CHECKSUM_EN
            csum_reg      <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            data_reg      <= data_next;
            xmit_reg      <= xmit_next;
            rd_en_reg     <= rd_en_next;
            pad_flag_reg  <= pad_flag_next;
            busy_reg      <= busy_next;
            frame_cnt_reg <= frame_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            pad_mode_reg  <= pad_mode_next;
            tmo_reg       <= tmo_next;
            done_prev_reg <= bus.xmit_done;
`ifdef FRAMER_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    assign bus.xmit       = xmit_reg;
    assign bus.xmit_data  = data_reg;
    assign bus.fifo_rd_en = rd_en_reg;
    assign busy           = busy_reg;
    assign pad_flag       = pad_flag_reg;
    assign frame_cnt      = frame_cnt_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: FIFO and UART transmitter models plus a byte-stream monitor.
module tb_uart_tx_framer;

    localparam int         PL   = 16;
    localparam int         TMO  = 1000;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAMER_CHECKSUM_EN
    localparam int         FB   = PL + 3;
`else
    localparam int         FB   = PL + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy, pad_flag;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    uart_tx_framer_if bus();

    uart_tx_framer #(.PAYLOAD_LEN(PL), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .pad_flag  (pad_flag),
        .frame_cnt (frame_cnt)
    );

    // FIFO model: data appears the cycle after the pop strobe.
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // UART model: done drops on xmit and returns high after uart_hold cycles.
    int   uart_hold;
    int   hold_cnt;
    logic uart_active;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.xmit_done <= 1'b1;
            hold_cnt      <= 0;
            uart_active   <= 1'b0;
        end else if (bus.xmit) begin
            bus.xmit_done <= 1'b0;
            hold_cnt      <= uart_hold;
            uart_active   <= 1'b1;
        end else if (hold_cnt > 1) begin
            hold_cnt <= hold_cnt - 1;
        end else if (hold_cnt == 1) begin
            hold_cnt      <= 0;
            bus.xmit_done <= 1'b1;
            uart_active   <= 1'b0;
        end
    end

    // Monitor sampled on the falling edge.
    logic [7:0] log_q [$];
    int   cyc = 0, n_xmit = 0, n_rd = 0, n_pad = 0, n_viol = 0;
    int   n_fall_sync = 0, last_rise_cyc = 0, pad_gap = 0, n_pad_noxmit = 0;
    logic done_prev_s = 1'b1, busy_prev_s = 1'b0, xmit_prev_s = 1'b0, rd_prev_s = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.xmit) begin
            log_q.push_back(bus.xmit_data);
            n_xmit = n_xmit + 1;
            if (uart_active || xmit_prev_s) n_viol = n_viol + 1;
        end
        if (bus.fifo_rd_en) begin
            n_rd = n_rd + 1;
            if (rd_prev_s) n_viol = n_viol + 1;
        end
        if (bus.xmit_done && !done_prev_s) last_rise_cyc = cyc;
        if (pad_flag) begin
            n_pad   = n_pad + 1;
            pad_gap = cyc - last_rise_cyc;
            if (!bus.xmit) n_pad_noxmit = n_pad_noxmit + 1;
        end
        if (busy_prev_s && !busy && bus.xmit && bus.xmit_data == SYNC)
            n_fall_sync = n_fall_sync + 1;
        done_prev_s = bus.xmit_done;
        busy_prev_s = busy;
        xmit_prev_s = bus.xmit;
        rd_prev_s   = bus.fifo_rd_en;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_frames(input string tag, input logic [15:0] target, input int budget);
        for (int k = 0; k < budget && frame_cnt !== target; k++) @(negedge clk);
        check(tag, {16'h0, frame_cnt}, {16'h0, target});
    endtask

    function automatic logic [31:0] logged(input int idx);
        return (idx < log_q.size()) ? {24'h0, log_q[idx]} : 32'hDEAD;
    endfunction

    // Compares a whole logged frame against SYNC, LEN, payload and (optionally) the XOR checksum.
    task automatic expect_frame(input string tag, input int base, input logic [7:0] pay [$]);
        logic [7:0] cs;
        logic [7:0] exp_b;
        cs = 8'(PL);
        for (int i = 0; i < PL; i++) cs = cs ^ pay[i];
        for (int i = 0; i < FB; i++) begin
            if (i == 0)           exp_b = SYNC;
            else if (i == 1)      exp_b = 8'(PL);
            else if (i < PL + 2)  exp_b = pay[i-2];
            else                  exp_b = cs;
            check($sformatf("%s_b%0d", tag, i), logged(base + i), {24'h0, exp_b});
        end
    endtask

    initial begin
        logic [7:0] pay [$];
        int base, base2, nx0, nr0, np0, nf0;

        rst_n     = 1'b0;
        uart_hold = 20;
        repeat (3) @(negedge clk);
        check("rst_xmit",  {31'h0, bus.xmit}, 32'h0);
        check("rst_rd",    {31'h0, bus.fifo_rd_en}, 32'h0);
        check("rst_data",  {24'h0, bus.xmit_data}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_pad",   {31'h0, pad_flag}, 32'h0);
        check("rst_fcnt",  {16'h0, frame_cnt}, 32'h0);

        // Full frame 00..0F
        for (int i = 0; i < 16; i++) push(8'(i));
        base = log_q.size(); nx0 = n_xmit; np0 = n_pad;
        rst_n = 1'b1;
        wait_frames("t1_fcnt", 16'd1, 3000);
        repeat (3) @(negedge clk);
        pay = {};
        for (int i = 0; i < PL; i++) pay.push_back(8'(i));
        expect_frame("t1", base, pay);
        check("t1_nxmit", n_xmit - nx0, FB);
        check("t1_busy", {31'h0, busy}, 32'h0);
        check("t1_npad", n_pad - np0, 0);

        // Short payload, timeout padding
        push(8'h11); push(8'h22); push(8'h33);
        base = log_q.size(); np0 = n_pad;
        wait_frames("t2_fcnt", 16'd2, 4000);
        repeat (3) @(negedge clk);
        pay = {8'h11, 8'h22, 8'h33};
        for (int i = 3; i < PL; i++) pay.push_back(8'h00);
        expect_frame("t2", base, pay);
        check("t2_npad", n_pad - np0, 1);
        check("t2_padgap", {31'h0, (pad_gap >= TMO && pad_gap <= TMO + 2)}, 32'h1);
        check("t2_padxmit", n_pad_noxmit, 0);

        // Two back-to-back frames
        for (int i = 0; i < 32; i++) push(8'(8'h40 + 8'(i * 7)));
        base = log_q.size(); nf0 = n_fall_sync;
        wait_frames("t3_fcnt", 16'd4, 3000);
        repeat (3) @(negedge clk);
        pay = {};
        for (int i = 0; i < PL; i++) pay.push_back(8'(8'h40 + 8'(i * 7)));
        expect_frame("t3a", base, pay);
        pay = {};
        for (int i = PL; i < 2 * PL; i++) pay.push_back(8'(8'h40 + 8'(i * 7)));
        expect_frame("t3b", base + FB, pay);
        check("t3_sync_on_busy_drop", n_fall_sync - nf0, 1);

        // Reset after the 5th payload byte's done edge
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        base = log_q.size();
        for (int k = 0; k < 1000 && log_q.size() < base + 7; k++) @(negedge clk);
        for (int k = 0; k < 60 && !bus.fifo_rd_en; k++) @(negedge clk);
        check("t4_rd_seen", {31'h0, bus.fifo_rd_en}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_xmit", {31'h0, bus.xmit}, 32'h0);
        check("t4_rd",   {31'h0, bus.fifo_rd_en}, 32'h0);
        check("t4_data", {24'h0, bus.xmit_data}, 32'h0);
        check("t4_busy", {31'h0, busy}, 32'h0);
        check("t4_fcnt", {16'h0, frame_cnt}, 32'h0);
        repeat (2) @(negedge clk);
        base2 = log_q.size();
        rst_n = 1'b1;
        for (int k = 0; k < 800 && log_q.size() < base2 + 13; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("t4_count", log_q.size() - base2, 13);
        check("t4_sync", logged(base2), {24'h0, SYNC});
        check("t4_len",  logged(base2 + 1), 32'(PL));
        for (int i = 0; i < 11; i++)
            check($sformatf("t4_b%0d", i), logged(base2 + 2 + i), 32'h85 + 32'(i));
        check("t4_busy_rd", {31'h0, busy}, 32'h1);
        check("t4_fcnt_rd", {16'h0, frame_cnt}, 32'h0);
        check("t4_drained", wr_ptr - rd_ptr, 0);

        // Long transmitter hold
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        uart_hold = 5000;
        push(8'hC3);
        base = log_q.size(); nx0 = n_xmit; nr0 = n_rd;
        rst_n = 1'b1;
        for (int k = 0; k < 20 && n_xmit == nx0; k++) @(negedge clk);
        check("t5_first", n_xmit - nx0, 1);
        repeat (2) @(negedge clk);
        uart_hold = 20;
        repeat (4800) @(negedge clk);
        check("t5_noxmit", n_xmit - nx0, 1);
        check("t5_nord",   n_rd - nr0, 0);
        check("t5_donelo", {31'h0, bus.xmit_done}, 32'h0);
        wait_frames("t5_fcnt", 16'd1, 4000);
        repeat (3) @(negedge clk);
        pay = {8'hC3};
        for (int i = 1; i < PL; i++) pay.push_back(8'h00);
        expect_frame("t5", base, pay);

        check("handshake_viol", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
